// File: rtl/clock_pkg.sv
// Shared widths, field limits and cursor codes for the time-of-day keeper.
package clock_pkg;

  localparam int unsigned FIELD_W = 6;
  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned CUR_W   = 3;

  localparam logic [CUR_W-1:0] CUR_SEC  = 3'b001;
  localparam logic [CUR_W-1:0] CUR_MIN  = 3'b010;
  localparam logic [CUR_W-1:0] CUR_HOUR = 3'b100;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter; carry_out flags an increment wrapping MAX -> 0.
module wrap_counter #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         carry_out
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic doInc;
  logic doDec;

  // Simultaneous inc and dec cancel out.
  assign doInc     = inc & ~dec;
  assign doDec     = dec & ~inc;
  assign carry_out = doInc && (count == MaxVal);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (doInc) begin
      count <= (count == MaxVal) ? '0 : count + W'(1);
    end else if (doDec) begin
      count <= (count == '0) ? MaxVal : count - W'(1);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// Time-of-day keeper: 1 Hz prescaler, sec/min/hour chain with carries,
// cursor-directed edits with deferred ticks, and a 12/24-hour formatter.
module time_of_day_counter #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned HOURS_DAY = 24,
  parameter int unsigned FIELD_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear,
  input  logic               up,
  input  logic               down,
  input  logic [2:0]         cursor,
  input  logic               mode_24h,
  output logic [FIELD_W-1:0] second_out,
  output logic [FIELD_W-1:0] minute_out,
  output logic [FIELD_W-1:0] hour_out,
  output logic               pm,
  output logic               sec_tick,
  output logic               day_pulse
);
  import clock_pkg::*;

  localparam int unsigned        PSC_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PSC_W-1:0]   PscLast  = PSC_W'(CLK_HZ - 1);
  localparam logic [FIELD_W-1:0] HalfDay  = FIELD_W'(HOURS_DAY / 2);

  logic [PSC_W-1:0]   prescaler;
  logic               tickPending;
  logic [FIELD_W-1:0] hourVal;

  logic tickNow;
  logic editValid;
  logic applyTick;
  logic secCarry, minCarry, hourCarry;
  logic secInc, secDec, minInc, minDec, hourInc, hourDec;

  // An edit needs exactly one direction and a one-hot cursor.
  assign editValid = (up ^ down) &&
                     (cursor == CUR_SEC || cursor == CUR_MIN || cursor == CUR_HOUR);
  assign tickNow   = run && (prescaler == PscLast);
  assign applyTick = !clear && !editValid && (tickPending || tickNow);

  // Tick increments ride the carry chain; edits touch one field and never carry.
  assign secInc  = applyTick | (editValid & up & (cursor == CUR_SEC));
  assign secDec  = editValid & down & (cursor == CUR_SEC);
  assign minInc  = (applyTick & secCarry) | (editValid & up & (cursor == CUR_MIN));
  assign minDec  = editValid & down & (cursor == CUR_MIN);
  assign hourInc = (applyTick & minCarry) | (editValid & up & (cursor == CUR_HOUR));
  assign hourDec = editValid & down & (cursor == CUR_HOUR);

  wrap_counter #(.MAX(SEC_MAX), .W(FIELD_W)) secCounter (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .inc      (secInc),
    .dec      (secDec),
    .count    (second_out),
    .carry_out(secCarry)
  );

  wrap_counter #(.MAX(MIN_MAX), .W(FIELD_W)) minCounter (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .inc      (minInc),
    .dec      (minDec),
    .count    (minute_out),
    .carry_out(minCarry)
  );

  wrap_counter #(.MAX(HOURS_DAY - 1), .W(FIELD_W)) hourCounter (
    .clk      (clk),
    .reset    (reset),
    .clr      (clear),
    .inc      (hourInc),
    .dec      (hourDec),
    .count    (hourVal),
    .carry_out(hourCarry)
  );

  // Prescaler, deferred-tick flag and output strobes.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prescaler   <= '0;
      tickPending <= 1'b0;
      sec_tick    <= 1'b0;
      day_pulse   <= 1'b0;
    end else begin
      if (run) begin
        prescaler <= tickNow ? '0 : prescaler + PSC_W'(1);
      end
      // An edit defers any due tick; otherwise a due tick is consumed now.
      tickPending <= editValid ? (tickPending | tickNow) : 1'b0;
      sec_tick    <= applyTick;
      day_pulse   <= applyTick & hourCarry;
    end
  end

  // 12-hour view maps 0 -> noon/midnight label, afternoon hours fold down.
  always_comb begin
    hour_out = hourVal;
    if (!mode_24h) begin
      if (hourVal == '0) begin
        hour_out = HalfDay;
      end else if (hourVal > HalfDay) begin
        hour_out = hourVal - HalfDay;
      end
    end
  end

  assign pm = (hourVal >= HalfDay);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter at CLK_HZ=4, HOURS_DAY=24.
module tb_time_of_day_counter;

  localparam int unsigned CLK_HZ    = 4;
  localparam int unsigned HOURS_DAY = 24;
  localparam int          DAY_SEC   = HOURS_DAY * 3600;

  logic       clk = 1'b0;
  logic       reset = 1'b1, run = 1'b0, clear = 1'b0, up = 1'b0, down = 1'b0;
  logic [2:0] cursor = 3'b000;
  logic       mode_24h = 1'b0;
  logic [5:0] second_out, minute_out, hour_out;
  logic       pm, sec_tick, day_pulse;

  time_of_day_counter #(.CLK_HZ(CLK_HZ), .HOURS_DAY(HOURS_DAY), .FIELD_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .clear     (clear),
    .up        (up),
    .down      (down),
    .cursor    (cursor),
    .mode_24h  (mode_24h),
    .second_out(second_out),
    .minute_out(minute_out),
    .hour_out  (hour_out),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .day_pulse (day_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [5:0] hourOut;
    logic       pm;
    logic       secTick;
    logic       dayPulse;
  } obs_t;

  obs_t sbq[$];
  obs_t expv, obsv;
  int   errors = 0;
  int   checks = 0;

  // Reference state: seconds since midnight, prescaler phase, deferred tick.
  int mTod = 0;
  int mPsc = 0;
  bit mPend = 1'b0;
  bit mSt = 1'b0;
  bit mDp = 1'b0;

  function automatic logic [5:0] fmt_hour(input int h, input logic m24);
    if (m24) return 6'(h);
    if (h == 0) return 6'd12;
    if (h > 12) return 6'(h - 12);
    return 6'(h);
  endfunction

  task automatic step(input logic r, input logic rn, input logic cl,
                      input logic u, input logic d, input logic [2:0] cur);
    bit tickNow, valid;
    int h, m, s, delta;
    if (r || cl) begin
      mTod = 0; mPsc = 0; mPend = 0; mSt = 0; mDp = 0;
    end else begin
      tickNow = rn && (mPsc == CLK_HZ - 1);
      if (rn) mPsc = tickNow ? 0 : mPsc + 1;
      valid = (u != d) && (cur == 3'b001 || cur == 3'b010 || cur == 3'b100);
      mSt = 0; mDp = 0;
      if (valid) begin
        h = mTod / 3600; m = (mTod / 60) % 60; s = mTod % 60;
        delta = u ? 1 : -1;
        if (cur == 3'b001) s = (s + delta + 60) % 60;
        if (cur == 3'b010) m = (m + delta + 60) % 60;
        if (cur == 3'b100) h = (h + delta + HOURS_DAY) % HOURS_DAY;
        mTod = h * 3600 + m * 60 + s;
        mPend = mPend | tickNow;
      end else if (mPend || tickNow) begin
        mTod = (mTod + 1) % DAY_SEC;
        mPend = 0;
        mSt = 1;
        mDp = (mTod == 0);
      end
    end
    expv.sec      = 6'(mTod % 60);
    expv.min      = 6'((mTod / 60) % 60);
    expv.hourOut  = fmt_hour(mTod / 3600, mode_24h);
    expv.pm       = ((mTod / 3600) >= HOURS_DAY / 2);
    expv.secTick  = mSt;
    expv.dayPulse = mDp;
    sbq.push_back(expv);
    reset = r; run = rn; clear = cl; up = u; down = d; cursor = cur;
    @(posedge clk);
    #1;
    obsv = '{second_out, minute_out, hour_out, pm, sec_tick, day_pulse};
    expv = sbq.pop_front();
  endtask

  task automatic test_reset();
    mode_24h = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 3'b000);
      if (obsv !== expv) begin errors++; $display("FAIL reset_sb: got %h exp %h", obsv, expv); end
      checks++;
    end
    if (hour_out !== 6'd12 || pm !== 1'b0) begin
      errors++; $display("FAIL reset_12h: got hour=%0d pm=%b exp 12/0", hour_out, pm);
    end
    checks++;
    mode_24h = 1'b1;
    #1;
    if (hour_out !== 6'd0 || second_out !== 6'd0 || sec_tick !== 1'b0) begin
      errors++; $display("FAIL reset_24h: got hour=%0d sec=%0d tick=%b exp 0/0/0", hour_out, second_out, sec_tick);
    end
    checks++;
  endtask

  task automatic test_run_ticks();
    int stCnt = 0;
    step(1, 0, 0, 0, 0, 3'b000);
    for (int i = 0; i < 240; i++) begin
      step(0, 1, 0, 0, 0, 3'b000);
      stCnt += int'(sec_tick);
      if (obsv !== expv) begin errors++; $display("FAIL run_sb i=%0d: got %h exp %h", i, obsv, expv); end
      checks++;
    end
    if (stCnt !== 60 || minute_out !== 6'd1 || second_out !== 6'd0) begin
      errors++; $display("FAIL run_count: got ticks=%0d min=%0d sec=%0d exp 60/1/0", stCnt, minute_out, second_out);
    end
    checks++;
  endtask

  task automatic test_day_wrap();
    int dpCnt = 0;
    logic pmBefore;
    step(0, 0, 1, 0, 0, 3'b000);
    step(0, 0, 0, 0, 1, 3'b100);
    step(0, 0, 0, 0, 1, 3'b010);
    step(0, 0, 0, 0, 1, 3'b001);
    if (obsv !== expv) begin errors++; $display("FAIL wrap_preload_sb: got %h exp %h", obsv, expv); end
    checks++;
    pmBefore = pm;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0, 3'b000);
      dpCnt += int'(day_pulse);
      if (obsv !== expv) begin errors++; $display("FAIL wrap_sb i=%0d: got %h exp %h", i, obsv, expv); end
      checks++;
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 3'b000);
      dpCnt += int'(day_pulse);
    end
    if (dpCnt !== 1 || pmBefore !== 1'b1 || pm !== 1'b0 ||
        hour_out !== 6'd0 || minute_out !== 6'd0 || second_out !== 6'd0) begin
      errors++; $display("FAIL wrap_day: got pulses=%0d pm %b->%b time %0d:%0d:%0d exp 1, 1->0, 0:0:0",
                         dpCnt, pmBefore, pm, hour_out, minute_out, second_out);
    end
    checks++;
  endtask

  task automatic test_edit_wrap();
    step(0, 0, 1, 0, 0, 3'b000);
    step(0, 0, 0, 0, 1, 3'b001);
    if (second_out !== 6'd59 || minute_out !== 6'd0) begin
      errors++; $display("FAIL edit_sec_down: got sec=%0d min=%0d exp 59/0", second_out, minute_out);
    end
    checks++;
    step(0, 0, 0, 0, 1, 3'b100);
    step(0, 0, 0, 1, 0, 3'b100);
    if (hour_out !== 6'd0 || day_pulse !== 1'b0 || second_out !== 6'd59) begin
      errors++; $display("FAIL edit_hour_up: got hour=%0d dp=%b sec=%0d exp 0/0/59", hour_out, day_pulse, second_out);
    end
    checks++;
    // Rejected edits: both directions, non-one-hot cursors.
    step(0, 0, 0, 1, 1, 3'b001);
    step(0, 0, 0, 1, 0, 3'b011);
    step(0, 0, 0, 0, 1, 3'b000);
    if (obsv !== expv || second_out !== 6'd59 || minute_out !== 6'd0) begin
      errors++; $display("FAIL edit_invalid: got %h exp %h", obsv, expv);
    end
    checks++;
  endtask

  task automatic test_collision();
    int stCnt = 0;
    step(0, 0, 1, 0, 0, 3'b000);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 3'b001);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 3'b000);
    step(0, 1, 0, 1, 0, 3'b010);
    stCnt += int'(sec_tick);
    if (minute_out !== 6'd1 || second_out !== 6'd10 || sec_tick !== 1'b0) begin
      errors++; $display("FAIL coll_edit: got min=%0d sec=%0d tick=%b exp 1/10/0", minute_out, second_out, sec_tick);
    end
    checks++;
    step(0, 1, 0, 0, 0, 3'b000);
    stCnt += int'(sec_tick);
    if (second_out !== 6'd11 || sec_tick !== 1'b1) begin
      errors++; $display("FAIL coll_pending: got sec=%0d tick=%b exp 11/1", second_out, sec_tick);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 3'b000);
      stCnt += int'(sec_tick);
    end
    if (stCnt !== 1) begin errors++; $display("FAIL coll_once: got ticks=%0d exp 1", stCnt); end
    checks++;
    // Back-to-back edits keep re-deferring the tick.
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 3'b000);
    step(0, 1, 0, 1, 0, 3'b010);
    step(0, 1, 0, 1, 0, 3'b010);
    if (obsv !== expv || sec_tick !== 1'b0) begin errors++; $display("FAIL b2b_defer: got %h exp %h", obsv, expv); end
    checks++;
    step(0, 1, 0, 0, 0, 3'b000);
    if (obsv !== expv || sec_tick !== 1'b1 || second_out !== 6'd12) begin
      errors++; $display("FAIL b2b_apply: got %h exp %h", obsv, expv);
    end
    checks++;
  endtask

  task automatic test_pause_clear();
    int firstTick = -1;
    step(0, 0, 1, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 3'b100);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 3'b010);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 3'b001);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 3'b000);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 3'b000);
      if (obsv !== expv) begin errors++; $display("FAIL pause_sb i=%0d: got %h exp %h", i, obsv, expv); end
      checks++;
    end
    step(0, 1, 0, 0, 0, 3'b000);
    step(0, 1, 0, 0, 0, 3'b000);
    if (sec_tick !== 1'b1 || second_out !== 6'd8) begin
      errors++; $display("FAIL pause_resume: got tick=%0b sec=%0d exp 1/8", sec_tick, second_out);
    end
    checks++;
    step(0, 0, 0, 0, 1, 3'b001);
    step(0, 1, 0, 0, 0, 3'b000);
    step(0, 1, 1, 0, 0, 3'b000);
    if (hour_out !== 6'd0 || minute_out !== 6'd0 || second_out !== 6'd0) begin
      errors++; $display("FAIL clear_zero: got %0d:%0d:%0d exp 0:0:0", hour_out, minute_out, second_out);
    end
    checks++;
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0, 0, 3'b000);
      if (sec_tick === 1'b1 && firstTick < 0) firstTick = i;
    end
    if (firstTick !== 4) begin errors++; $display("FAIL clear_psc: got first tick at %0d exp 4", firstTick); end
    checks++;
    // Clear and reset arriving on the tick cycle at the last second of the day.
    for (int k = 0; k < 2; k++) begin
      step(0, 0, 1, 0, 0, 3'b000);
      step(0, 0, 0, 0, 1, 3'b100);
      step(0, 0, 0, 0, 1, 3'b010);
      step(0, 0, 0, 0, 1, 3'b001);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 3'b000);
      step(k == 1, 1, k == 0, 0, 0, 3'b000);
      if (obsv !== expv || day_pulse !== 1'b0 || sec_tick !== 1'b0 || second_out !== 6'd0) begin
        errors++; $display("FAIL zero_wins k=%0d: got %h exp %h", k, obsv, expv);
      end
      checks++;
      step(0, 1, 0, 0, 0, 3'b000);
      if (obsv !== expv) begin errors++; $display("FAIL zero_after k=%0d: got %h exp %h", k, obsv, expv); end
      checks++;
    end
  endtask

  task automatic test_12h();
    int         hrs[5]  = '{0, 1, 12, 13, 23};
    logic [5:0] exp12[5] = '{6'd12, 6'd1, 6'd12, 6'd1, 6'd11};
    logic       expPm[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    mode_24h = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step(0, 0, 1, 0, 0, 3'b000);
      if (hrs[j] == 23) step(0, 0, 0, 0, 1, 3'b100);
      else for (int k = 0; k < hrs[j]; k++) step(0, 0, 0, 1, 0, 3'b100);
      if (obsv !== expv) begin errors++; $display("FAIL fmt_sb h=%0d: got %h exp %h", hrs[j], obsv, expv); end
      checks++;
      if (hour_out !== exp12[j] || pm !== expPm[j]) begin
        errors++; $display("FAIL fmt12 h=%0d: got %0d pm=%b exp %0d pm=%b", hrs[j], hour_out, pm, exp12[j], expPm[j]);
      end
      checks++;
      mode_24h = 1'b1;
      #1;
      if (hour_out !== 6'(hrs[j]) || pm !== expPm[j]) begin
        errors++; $display("FAIL fmt24 h=%0d: got %0d pm=%b exp %0d pm=%b", hrs[j], hour_out, pm, hrs[j], expPm[j]);
      end
      checks++;
      mode_24h = 1'b0;
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_run_ticks();
    test_day_wrap();
    test_edit_wrap();
    test_collision();
    test_pause_clear();
    test_12h();
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d entries exp 0", sbq.size()); end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
